// File: rtl/pipe_hazard_pkg.sv
// Shared definitions for the pipeline hazard scheduler: bypass select codes
// and the class flags carried by each scoreboard entry.
package pipe_hazard_pkg;

    typedef enum logic [1:0] {
        BYP_RF = 2'd0,
        BYP_X  = 2'd1,
        BYP_M  = 2'd2,
        BYP_W  = 2'd3
    } byp_sel_e;

    localparam int BYP_SEL_W = 2;

    typedef struct packed {
        logic is_load;
        logic is_mul;
    } sb_class_t;

    localparam int SB_CLASS_W = $bits(sb_class_t);

endpackage

// File: rtl/pipe_sb_entry.sv
// One scoreboard entry (in-flight register write) with two source-match ports.
// Load has priority over clear; with neither asserted the entry holds.
module pipe_sb_entry
    import pipe_hazard_pkg::*;
#(
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_load,
    input  logic               i_clear,
    input  logic               i_val,
    input  logic [RADDR_W-1:0] i_waddr,
    input  sb_class_t          i_cls,
    input  logic               i_a_en,
    input  logic [RADDR_W-1:0] i_a_idx,
    input  logic               i_b_en,
    input  logic [RADDR_W-1:0] i_b_idx,
    output logic               o_val,
    output logic [RADDR_W-1:0] o_waddr,
    output sb_class_t          o_cls,
    output logic               o_a_match,
    output logic               o_b_match
);

    logic               r_val;
    logic [RADDR_W-1:0] r_waddr;
    logic [SB_CLASS_W-1:0] r_cls;

    // NOTE: state registers use non-blocking assignments so every entry samples
    // its neighbour's pre-edge value; blocking here would ripple X->M->W in one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_val   <= 1'b0;
            r_waddr <= '0;
            r_cls   <= '0;
        end else if (i_load) begin
            r_val   <= i_val;
            r_waddr <= i_waddr;
            r_cls   <= i_cls;
        end else if (i_clear) begin
            r_val   <= 1'b0;
        end
    end

    assign o_val     = r_val;
    assign o_waddr   = r_waddr;
    assign o_cls     = sb_class_t'(r_cls);
    assign o_a_match = i_a_en && (i_a_idx != '0) && r_val && (r_waddr == i_a_idx);
    assign o_b_match = i_b_en && (i_b_idx != '0) && r_val && (r_waddr == i_b_idx);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard scheduler for the 5-stage core: X/M/W write scoreboard, multiply busy
// counter, D/X stall and X squash generation, and D-stage bypass selects.
module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int MUL_LAT = 4,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               d_val,
    input  logic               d_rs_en,
    input  logic               d_rt_en,
    input  logic [RADDR_W-1:0] d_rs,
    input  logic [RADDR_W-1:0] d_rt,
    input  logic               d_wen,
    input  logic [RADDR_W-1:0] d_waddr,
    input  logic               d_is_load,
    input  logic               d_is_mul,
    input  logic               d_go,
    input  logic               x_go,
    input  logic               m_go,
    input  logic               w_go,
    input  logic               x_br_taken,
    output logic               d_stall,
    output logic               x_stall,
    output logic               x_squash,
    output logic [1:0]         d_rs_byp,
    output logic [1:0]         d_rt_byp
);

    localparam int MCNT_W = $clog2(MUL_LAT);

    logic [MCNT_W-1:0]  r_mcnt;

    // Index 0/1/2 = X/M/W entry; each loads from the stage before it.
    logic               w_ld      [3];
    logic               w_clr     [3];
    logic               w_src_val [3];
    logic [RADDR_W-1:0] w_src_adr [3];
    sb_class_t          w_src_cls [3];
    logic               w_val     [3];
    logic [RADDR_W-1:0] w_waddr   [3];
    sb_class_t          w_cls     [3];
    logic               w_rs_hit  [3];
    logic               w_rt_hit  [3];

    byp_sel_e           w_rs_sel;
    byp_sel_e           w_rt_sel;
    logic               w_x_hold;

    always_comb begin
        w_ld[0]      = d_go;
        w_ld[1]      = x_go;
        w_ld[2]      = m_go;
        w_clr[0]     = x_go;
        w_clr[1]     = m_go;
        w_clr[2]     = w_go;
        w_src_val[0] = d_wen && (d_waddr != '0);
        w_src_adr[0] = d_waddr;
        w_src_cls[0] = '{is_load: d_is_load, is_mul: d_is_mul};
        w_src_val[1] = w_val[0];
        w_src_adr[1] = w_waddr[0];
        w_src_cls[1] = w_cls[0];
        w_src_val[2] = w_val[1];
        w_src_adr[2] = w_waddr[1];
        w_src_cls[2] = w_cls[1];
    end

    for (genvar g = 0; g < 3; g++) begin : g_sb
        pipe_sb_entry #(.RADDR_W(RADDR_W)) u_entry (
            .clk       (clk),
            .reset     (reset),
            .i_load    (w_ld[g]),
            .i_clear   (w_clr[g]),
            .i_val     (w_src_val[g]),
            .i_waddr   (w_src_adr[g]),
            .i_cls     (w_src_cls[g]),
            .i_a_en    (d_rs_en),
            .i_a_idx   (d_rs),
            .i_b_en    (d_rt_en),
            .i_b_idx   (d_rt),
            .o_val     (w_val[g]),
            .o_waddr   (w_waddr[g]),
            .o_cls     (w_cls[g]),
            .o_a_match (w_rs_hit[g]),
            .o_b_match (w_rt_hit[g])
        );
    end

    // A new multiply reloads the count even if one is still running.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mcnt <= '0;
        end else if (d_go && d_is_mul) begin
            r_mcnt <= MCNT_W'(MUL_LAT - 1);
        end else if (r_mcnt != '0) begin
            r_mcnt <= r_mcnt - MCNT_W'(1);
        end
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_rs_sel = BYP_RF;
        w_rt_sel = BYP_RF;
        if (w_rs_hit[2]) w_rs_sel = BYP_W;
        if (w_rs_hit[1]) w_rs_sel = BYP_M;
        if (w_rs_hit[0]) w_rs_sel = BYP_X;
        if (w_rt_hit[2]) w_rt_sel = BYP_W;
        if (w_rt_hit[1]) w_rt_sel = BYP_M;
        if (w_rt_hit[0]) w_rt_sel = BYP_X;
    end

    // Only a result still being produced in X can't be forwarded yet.
    assign w_x_hold = w_cls[0].is_load || (w_cls[0].is_mul && (r_mcnt != '0));

    assign d_stall  = d_val && w_x_hold && ((w_rs_sel == BYP_X) || (w_rt_sel == BYP_X));
    assign x_stall  = (r_mcnt != '0);
    assign x_squash = x_br_taken;
    assign d_rs_byp = w_rs_sel;
    assign d_rt_byp = w_rt_sel;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a stage-list reference model.
module tb_pipe_hazard_ctrl;

    localparam int MUL_LAT = 4;
    localparam int RADDR_W = 5;

    typedef struct {
        bit         d_val, rs_en, rt_en;
        bit [4:0]   rs, rt;
        bit         wen;
        bit [4:0]   waddr;
        bit         ld, mul, d_go, x_go, m_go, w_go, br;
    } stim_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               d_val, d_rs_en, d_rt_en, d_wen, d_is_load, d_is_mul;
    logic [RADDR_W-1:0] d_rs, d_rt, d_waddr;
    logic               d_go, x_go, m_go, w_go, x_br_taken;
    logic               d_stall, x_stall, x_squash;
    logic [1:0]         d_rs_byp, d_rt_byp;

    int    n_checks = 0;
    int    n_pass   = 0;
    stim_t cur;

    // Reference model: what is in flight in X, M, W (index 0..2), plus the
    // number of cycles the multiply in X still needs.
    int m_v   [3];
    int m_dst [3];
    int m_ld  [3];
    int m_mul [3];
    int m_left;

    pipe_hazard_ctrl #(.MUL_LAT(MUL_LAT), .RADDR_W(RADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .d_val      (d_val),
        .d_rs_en    (d_rs_en),
        .d_rt_en    (d_rt_en),
        .d_rs       (d_rs),
        .d_rt       (d_rt),
        .d_wen      (d_wen),
        .d_waddr    (d_waddr),
        .d_is_load  (d_is_load),
        .d_is_mul   (d_is_mul),
        .d_go       (d_go),
        .x_go       (x_go),
        .m_go       (m_go),
        .w_go       (w_go),
        .x_br_taken (x_br_taken),
        .d_stall    (d_stall),
        .x_stall    (x_stall),
        .x_squash   (x_squash),
        .d_rs_byp   (d_rs_byp),
        .d_rt_byp   (d_rt_byp)
    );

    always #5 clk = ~clk;

    function automatic stim_t idle();
        stim_t s;
        s = '{default: '0};
        return s;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_v[i] = 0; m_dst[i] = 0; m_ld[i] = 0; m_mul[i] = 0;
        end
        m_left = 0;
    endtask

    // Bypass source: the youngest in-flight write to the same nonzero register.
    function automatic int exp_sel(bit en, int idx);
        if (en && idx != 0)
            for (int s = 0; s < 3; s++)
                if (m_v[s] != 0 && m_dst[s] == idx) return s + 1;
        return 0;
    endfunction

    function automatic bit exp_hold(int sel);
        return (sel == 1) && (m_ld[0] != 0 || (m_mul[0] != 0 && m_left > 0));
    endfunction

    task automatic model_update(input stim_t s);
        if (s.m_go) begin
            m_v[2] = m_v[1]; m_dst[2] = m_dst[1]; m_ld[2] = m_ld[1]; m_mul[2] = m_mul[1];
        end else if (s.w_go) m_v[2] = 0;
        if (s.x_go) begin
            m_v[1] = m_v[0]; m_dst[1] = m_dst[0]; m_ld[1] = m_ld[0]; m_mul[1] = m_mul[0];
        end else if (s.m_go) m_v[1] = 0;
        if (s.d_go) begin
            m_v[0]   = (s.wen && s.waddr != 0) ? 1 : 0;
            m_dst[0] = int'(s.waddr);
            m_ld[0]  = int'(s.ld);
            m_mul[0] = int'(s.mul);
        end else if (s.x_go) m_v[0] = 0;
        if (s.d_go && s.mul) m_left = MUL_LAT - 1;
        else if (m_left > 0) m_left = m_left - 1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic check_model(input string tag);
        int rs_s, rt_s;
        rs_s = exp_sel(cur.rs_en, int'(cur.rs));
        rt_s = exp_sel(cur.rt_en, int'(cur.rt));
        check({tag, ".rs_byp"},   32'(d_rs_byp), 32'(rs_s));
        check({tag, ".rt_byp"},   32'(d_rt_byp), 32'(rt_s));
        check({tag, ".d_stall"},  32'(d_stall),  32'(cur.d_val && (exp_hold(rs_s) || exp_hold(rt_s))));
        check({tag, ".x_stall"},  32'(x_stall),  32'(m_left > 0));
        check({tag, ".x_squash"}, 32'(x_squash), 32'(cur.br));
    endtask

    task automatic drive(input stim_t s, input string tag);
        cur        = s;
        d_val      = s.d_val;
        d_rs_en    = s.rs_en;
        d_rt_en    = s.rt_en;
        d_rs       = s.rs;
        d_rt       = s.rt;
        d_wen      = s.wen;
        d_waddr    = s.waddr;
        d_is_load  = s.ld;
        d_is_mul   = s.mul;
        d_go       = s.d_go;
        x_go       = s.x_go;
        m_go       = s.m_go;
        w_go       = s.w_go;
        x_br_taken = s.br;
        #1;
        check_model(tag);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_update(cur);
        @(negedge clk);
    endtask

    initial begin
        stim_t s;
        model_reset();

        // Reset holds everything quiet even with a valid D reading r3.
        reset = 1'b0;
        s = idle(); s.d_val = 1; s.rs_en = 1; s.rs = 3;
        drive(s, "rst_hold");
        check("rst_hold.d_stall", 32'(d_stall), 0);
        check("rst_hold.rs_byp", 32'(d_rs_byp), 0);
        tick();
        reset = 1'b1;
        drive(idle(), "rst_rel");
        tick();
        drive(idle(), "rst_idle");
        tick();

        // ALU forwarding of r5 through X, M, W, then from the register file.
        s = idle(); s.d_val = 1; s.d_go = 1; s.wen = 1; s.waddr = 5;
        drive(s, "alu_w"); tick();
        s = idle(); s.d_val = 1; s.rs_en = 1; s.rs = 5; s.x_go = 1;
        drive(s, "alu_x");
        check("alu_x.rs_byp", 32'(d_rs_byp), 1);
        check("alu_x.d_stall", 32'(d_stall), 0);
        tick();
        s.x_go = 0; s.m_go = 1;
        drive(s, "alu_m"); check("alu_m.rs_byp", 32'(d_rs_byp), 2); tick();
        s.m_go = 0; s.w_go = 1;
        drive(s, "alu_wb"); check("alu_wb.rs_byp", 32'(d_rs_byp), 3); tick();
        s.w_go = 0;
        drive(s, "alu_rf"); check("alu_rf.rs_byp", 32'(d_rs_byp), 0); tick();

        // Load-use: one stall cycle, then forward from M.
        s = idle(); s.d_val = 1; s.d_go = 1; s.wen = 1; s.waddr = 7; s.ld = 1;
        drive(s, "lu_w"); tick();
        s = idle(); s.d_val = 1; s.rt_en = 1; s.rt = 7; s.x_go = 1;
        drive(s, "lu_1");
        check("lu_1.d_stall", 32'(d_stall), 1);
        check("lu_1.rt_byp", 32'(d_rt_byp), 1);
        tick();
        s.x_go = 0; s.d_go = 1; s.m_go = 1;
        drive(s, "lu_2");
        check("lu_2.d_stall", 32'(d_stall), 0);
        check("lu_2.rt_byp", 32'(d_rt_byp), 2);
        tick();

        // Multiply to r9: MUL_LAT-1 cycles of X and dependent-D stall.
        s = idle(); s.d_val = 1; s.d_go = 1; s.wen = 1; s.waddr = 9; s.mul = 1;
        drive(s, "mul_w"); tick();
        s = idle(); s.d_val = 1; s.rs_en = 1; s.rs = 9;
        for (int i = 0; i < MUL_LAT - 1; i++) begin
            drive(s, $sformatf("mul_busy%0d", i));
            check("mul_busy.x_stall", 32'(x_stall), 1);
            check("mul_busy.d_stall", 32'(d_stall), 1);
            tick();
        end
        s.x_go = 1; s.d_go = 1;
        drive(s, "mul_done");
        check("mul_done.x_stall", 32'(x_stall), 0);
        check("mul_done.d_stall", 32'(d_stall), 0);
        check("mul_done.rs_byp", 32'(d_rs_byp), 1);
        tick();
        s = idle(); s.d_go = 1; s.x_go = 1; s.m_go = 1; s.w_go = 1;
        for (int i = 0; i < 3; i++) begin drive(s, "drain"); tick(); end

        // r0 writes never match; r4 in both X and M resolves to X.
        s = idle(); s.d_val = 1; s.d_go = 1; s.wen = 1; s.waddr = 0;
        drive(s, "r0_w"); tick();
        s.waddr = 4; s.x_go = 1; s.rs_en = 1; s.rs = 0;
        drive(s, "r0_rd"); check("r0_rd.rs_byp", 32'(d_rs_byp), 0); tick();
        s.rs_en = 0;
        drive(s, "r4_w2"); tick();
        s = idle(); s.d_val = 1; s.rs_en = 1; s.rs = 4; s.rt_en = 1; s.rt = 0;
        drive(s, "prio");
        check("prio.rs_byp", 32'(d_rs_byp), 1);
        check("prio.rt_byp", 32'(d_rt_byp), 0);
        tick();

        // Taken branch squashes D; the squashed write of r8 never enters X.
        s = idle(); s.d_val = 1; s.d_go = 1; s.wen = 1; s.waddr = 6; s.x_go = 1;
        drive(s, "br_w"); tick();
        s = idle(); s.d_val = 1; s.wen = 1; s.waddr = 8; s.br = 1; s.x_go = 1;
        drive(s, "br_sq"); check("br_sq.x_squash", 32'(x_squash), 1); tick();
        s = idle(); s.d_val = 1; s.rs_en = 1; s.rs = 6; s.rt_en = 1; s.rt = 8;
        drive(s, "br_after");
        check("br_after.rs_byp", 32'(d_rs_byp), 2);
        check("br_after.rt_byp", 32'(d_rt_byp), 0);
        check("br_after.x_squash", 32'(x_squash), 0);
        tick();

        // Asynchronous reset in the middle of a multiply abandons the count.
        s = idle(); s.d_val = 1; s.d_go = 1; s.wen = 1; s.waddr = 10; s.mul = 1;
        drive(s, "rm_w"); tick();
        s = idle(); s.d_val = 1; s.rs_en = 1; s.rs = 10; s.br = 1;
        drive(s, "rm_busy"); check("rm_busy.x_stall", 32'(x_stall), 1);
        reset = 1'b0;
        model_reset();
        #1;
        check("rm_rst.x_stall", 32'(x_stall), 0);
        check("rm_rst.d_stall", 32'(d_stall), 0);
        check("rm_rst.rs_byp", 32'(d_rs_byp), 0);
        check("rm_rst.x_squash", 32'(x_squash), 1);
        #1;
        reset = 1'b1;
        drive(idle(), "rm_rel"); tick();

        // Random traffic against the model; small register range for frequent hits.
        for (int n = 0; n < 400; n++) begin
            s = idle();
            s.d_val = 1'($urandom_range(0, 1));
            s.rs_en = 1'($urandom_range(0, 1));
            s.rt_en = 1'($urandom_range(0, 1));
            s.rs    = 5'($urandom_range(0, 3));
            s.rt    = 5'($urandom_range(0, 3));
            s.wen   = 1'($urandom_range(0, 1));
            s.waddr = 5'($urandom_range(0, 3));
            s.ld    = ($urandom_range(0, 3) == 0);
            s.mul   = !s.ld && ($urandom_range(0, 5) == 0);
            s.d_go  = s.d_val && ($urandom_range(0, 3) != 0);
            s.x_go  = ($urandom_range(0, 3) != 0);
            s.m_go  = ($urandom_range(0, 3) != 0);
            s.w_go  = ($urandom_range(0, 3) != 0);
            s.br    = ($urandom_range(0, 7) == 0);
            drive(s, $sformatf("rnd%0d", n));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
